// File: rtl/lfp_mul_rr_arbiter.sv
// Round-robin front end sharing one external E4M3 LFP multiplier among NREQ requesters,
// with a single backpressured response slot holding {product, requester id}.
module lfp_mul_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ),
  parameter int CNTW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*8-1:0] req_x1,
  input  logic [NREQ*8-1:0] req_x2,
  output logic [7:0]        mul_x1,
  output logic [7:0]        mul_x2,
  input  logic [8:0]        mul_y,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [8:0]        rsp_y,
  output logic [IDW-1:0]    rsp_id,
  output logic [CNTW-1:0]   ops_cnt
);

  typedef enum logic {S_EMPTY, S_FULL} state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [8:0]      rsp_y_q, rsp_y_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [CNTW-1:0] ops_cnt_q, ops_cnt_d;

  logic            can_issue;
  logic            gnt_vld;
  logic [IDW-1:0]  gnt_idx;
  int              cand;

  // First valid requester at or after rr_ptr, wrapping modulo NREQ; blocked while in reset
  always_comb begin
    can_issue = (state_q == S_EMPTY) || rsp_ready;
    gnt_vld   = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!gnt_vld && can_issue && !rst && req_valid[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDW'(cand);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    mul_x1    = 8'h00;
    mul_x2    = 8'h00;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_vld && (gnt_idx == IDW'(k))) begin
        req_ready[k] = 1'b1;
        mul_x1       = req_x1[8*k +: 8];
        mul_x2       = req_x2[8*k +: 8];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    rsp_y_d   = rsp_y_q;
    rsp_id_d  = rsp_id_q;
    ops_cnt_d = ops_cnt_q;
    if (gnt_vld) begin
      // A grant refills the slot on the same edge it drains, so no bubble
      state_d   = S_FULL;
      rsp_y_d   = mul_y;
      rsp_id_d  = gnt_idx;
      rr_ptr_d  = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
      ops_cnt_d = ops_cnt_q + CNTW'(1);
    end else if ((state_q == S_FULL) && rsp_ready) begin
      state_d = S_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_EMPTY;
      rr_ptr_q  <= '0;
      rsp_y_q   <= 9'h000;
      rsp_id_q  <= '0;
      ops_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      rsp_y_q   <= rsp_y_d;
      rsp_id_q  <= rsp_id_d;
      ops_cnt_q <= ops_cnt_d;
    end
  end

  assign rsp_valid = (state_q == S_FULL);
  assign rsp_y     = rsp_y_q;
  assign rsp_id    = rsp_id_q;
  assign ops_cnt   = ops_cnt_q;

endmodule

// File: tb/tb_lfp_mul_rr_arbiter.sv
// Scoreboard bench for lfp_mul_rr_arbiter: a reference arbiter model predicts grants,
// expected responses are queued at grant time and checked when the slot is consumed.
module tb_lfp_mul_rr_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int CNTW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*8-1:0] req_x1, req_x2;
  logic [7:0]        mul_x1, mul_x2;
  logic [8:0]        mul_y;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [8:0]        rsp_y;
  logic [IDW-1:0]    rsp_id;
  logic [CNTW-1:0]   ops_cnt;

  logic [3:0] rv;
  logic [7:0] rx1 [NREQ];
  logic [7:0] rx2 [NREQ];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit         m_full;
  int         m_ptr;
  int         m_cnt;
  logic [8:0] m_y;
  logic [1:0] m_id;
  logic [3:0] last_rr;
  logic [10:0] exp_q [$];

  always #5 clk = ~clk;

  // Stand-in for the external multiplier: log-domain add of magnitudes, sign xor
  function automatic logic [8:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] s;
    s = {1'b0, a[6:0]} + {1'b0, b[6:0]};
    return {a[7] ^ b[7], s};
  endfunction

  assign mul_y     = ref_mul(mul_x1, mul_x2);
  assign req_valid = rv;

  always_comb begin
    req_x1 = '0;
    req_x2 = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_x1[8*i +: 8] = rx1[i];
      req_x2[8*i +: 8] = rx2[i];
    end
  end

  lfp_mul_rr_arbiter #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x1    (req_x1),
    .req_x2    (req_x2),
    .mul_x1    (mul_x1),
    .mul_x2    (mul_x2),
    .mul_y     (mul_y),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y),
    .rsp_id    (rsp_id),
    .ops_cnt   (ops_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_full = 1'b0;
    m_ptr  = 0;
    m_cnt  = 0;
    m_y    = 9'h000;
    m_id   = 2'd0;
    exp_q.delete();
  endtask

  // Called at posedge+1; evaluates one clock cycle against the model
  task automatic cycle(output int g);
    bit         can;
    logic [3:0] exp_rr;
    logic [10:0] e;
    @(negedge clk);
    can = !m_full || rsp_ready;
    g = -1;
    if (can) begin
      for (int k = 0; k < NREQ; k++) begin
        int c;
        c = (m_ptr + k) % NREQ;
        if (g < 0 && rv[c]) g = c;
      end
    end
    exp_rr  = (g >= 0) ? 4'(1 << g) : 4'b0000;
    last_rr = req_ready;
    check_eq("req_ready", 32'(req_ready), 32'(exp_rr));
    check_eq("mul_x1", 32'(mul_x1), (g >= 0) ? 32'(rx1[g]) : 32'h0);
    check_eq("mul_x2", 32'(mul_x2), (g >= 0) ? 32'(rx2[g]) : 32'h0);
    if (m_full && rsp_ready && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("sb_rsp_y", 32'(rsp_y), 32'(e[10:2]));
      check_eq("sb_rsp_id", 32'(rsp_id), 32'(e[1:0]));
    end
    if (g >= 0) begin
      m_y    = ref_mul(rx1[g], rx2[g]);
      m_id   = 2'(g);
      exp_q.push_back({m_y, m_id});
      m_ptr  = (g + 1) % NREQ;
      m_cnt  = (m_cnt + 1) % (1 << CNTW);
      m_full = 1'b1;
    end else if (m_full && rsp_ready) begin
      m_full = 1'b0;
    end
    @(posedge clk);
    #1;
    check_eq("rsp_valid", 32'(rsp_valid), 32'(m_full));
    check_eq("ops_cnt", 32'(ops_cnt), 32'(m_cnt));
    check_eq("rsp_y", 32'(rsp_y), 32'(m_y));
    check_eq("rsp_id", 32'(rsp_id), 32'(m_id));
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    rv        = '0;
    rsp_ready = 1'b0;
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      rx1[i] = 8'($urandom);
      rx2[i] = 8'($urandom);
    end
  endtask

  initial begin
    int g;
    int order [6];
    order = '{0, 1, 2, 3, 0, 1};
    rst = 1'b1;
    rv = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      rx1[i] = 8'h00;
      rx2[i] = 8'h00;
    end
    model_reset();
    #3;
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check_eq("rst_rsp_y", 32'(rsp_y), 32'h0);
    check_eq("rst_ops_cnt", 32'(ops_cnt), 32'h0);
    check_eq("rst_req_ready", 32'(req_ready), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single operation: 1.0 x 1.0 from requester 1
    rx1[1] = 8'h40;
    rx2[1] = 8'h40;
    rv = 4'b0010;
    rsp_ready = 1'b1;
    cycle(g);
    check_eq("single_y", 32'(rsp_y), 32'h080);
    check_eq("single_id", 32'(rsp_id), 32'h1);
    check_eq("single_cnt", 32'(ops_cnt), 32'h1);
    rv = '0;
    cycle(g);

    // Round-robin with all requesters valid
    do_reset();
    rsp_ready = 1'b1;
    rv = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      rand_ops();
      cycle(g);
      check_eq("rr_order", 32'(last_rr), 32'(1 << order[i]));
    end
    check_eq("rr_cnt", 32'(ops_cnt), 32'd6);
    rv = '0;
    cycle(g);

    // Backpressure after the first grant
    do_reset();
    rand_ops();
    rv = 4'b1111;
    rsp_ready = 1'b1;
    cycle(g);
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle(g);
      check_eq("bp_stall_rr", 32'(last_rr), 32'h0);
      check_eq("bp_stall_cnt", 32'(ops_cnt), 32'h1);
    end
    rsp_ready = 1'b1;
    cycle(g);
    check_eq("bp_release", 32'(last_rr), 32'b0010);
    rsp_ready = 1'b0;

    // Asynchronous reset mid-cycle with the slot full
    rst = 1'b1;
    #1;
    check_eq("arst_rsp_valid", 32'(rsp_valid), 32'h0);
    check_eq("arst_ops_cnt", 32'(ops_cnt), 32'h0);
    check_eq("arst_req_ready", 32'(req_ready), 32'h0);
    check_eq("arst_mul_x1", 32'(mul_x1), 32'h0);
    model_reset();
    #1;
    rst = 1'b0;
    rv = 4'b0100;
    rsp_ready = 1'b1;
    cycle(g);
    check_eq("arst_after", 32'(last_rr), 32'b0100);
    rv = '0;
    cycle(g);

    // Sparse requests; requester 3 withdraws before its turn
    do_reset();
    rsp_ready = 1'b1;
    rand_ops();
    rv = 4'b1001;
    cycle(g);
    rv = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      rand_ops();
      cycle(g);
      check_eq("sparse_grant", 32'(last_rr), 32'b0001);
    end
    rv = '0;
    cycle(g);

    // Random traffic with random backpressure
    do_reset();
    for (int n = 0; n < 300; n++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!rv[i] && $urandom_range(0, 1) == 1) begin
          rv[i]  = 1'b1;
          rx1[i] = 8'($urandom);
          rx2[i] = 8'($urandom);
        end
      end
      cycle(g);
      if (g >= 0) rv[g] = 1'b0;
    end
    rv = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle(g);

    // Counter wrap with a 4-bit counter
    do_reset();
    rsp_ready = 1'b1;
    rv = 4'b1111;
    for (int i = 0; i < 17; i++) begin
      rand_ops();
      cycle(g);
    end
    check_eq("cnt_wrap", 32'(ops_cnt), 32'h1);
    rv = '0;
    cycle(g);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
